// File: rtl/signed_vector_scalar_division.sv
// Sequential divide of a 3-component sign-magnitude fixed-point vector by a
// sign-magnitude scalar. Three radix-2 restoring dividers (x, y, z) run in
// lockstep with a fixed latency of ITER iterations. Valid/ready handshake on
// both the operand and the result side.
module signed_vector_scalar_division #(
  parameter int COMP_WIDTH = 19,
  parameter int FRAC_BITS  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3*COMP_WIDTH-1:0] in_vector,
  input  logic [COMP_WIDTH-1:0]   in_scalar,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3*COMP_WIDTH-1:0] out_vector,
  output logic [2:0]              out_overflow,
  output logic                    out_div_by_zero
);

  localparam int MAG_W = COMP_WIDTH - 1;
  localparam int ITER  = MAG_W + FRAC_BITS;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One restoring-division step. Returns {quotient bit, new remainder}.
  // The remainder is always below the divisor after a step, so only the low
  // MAG_W bits of the subtraction are meaningful.
  function automatic logic [MAG_W:0] div_step(
    input logic [MAG_W-1:0] rem,
    input logic             dvd_bit,
    input logic [MAG_W-1:0] dmag
  );
    logic [MAG_W:0] rem_sh;
    rem_sh = {rem, dvd_bit};
    if (rem_sh >= {1'b0, dmag}) begin
      div_step = {1'b1, rem_sh[MAG_W-1:0] - dmag};
    end else begin
      div_step = {1'b0, rem_sh[MAG_W-1:0]};
    end
  endfunction

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [ITER-1:0]    dvd_r  [3];
  logic [MAG_W-1:0]   rem_r  [3];
  logic [ITER-1:0]    quot_r [3];
  logic [MAG_W-1:0]   dmag_r;
  logic [2:0]         sign_r;
  logic               dz_r;

  logic [MAG_W-1:0]        rem_nx_s  [3];
  logic [ITER-1:0]         quot_nx_s [3];
  logic [3*COMP_WIDTH-1:0] res_vec_s;
  logic [2:0]              res_ovf_s;

  // Next iteration of all three dividers plus the saturated/signed result
  // that the final iteration produces.
  always_comb begin
    res_vec_s = {(3*COMP_WIDTH){1'b0}};
    res_ovf_s = 3'b000;
    for (int c = 0; c < 3; c++) begin
      logic [MAG_W:0]   step_s;
      logic             sat_s;
      logic [MAG_W-1:0] mag_s;
      step_s        = div_step(rem_r[c], dvd_r[c][ITER-1], dmag_r);
      rem_nx_s[c]   = step_s[MAG_W-1:0];
      quot_nx_s[c]  = {quot_r[c][ITER-2:0], step_s[MAG_W]};
      sat_s         = (|quot_nx_s[c][ITER-1:MAG_W]) | dz_r;
      if (sat_s) begin
        mag_s = {MAG_W{1'b1}};
      end else begin
        mag_s = quot_nx_s[c][MAG_W-1:0];
      end
      res_vec_s[(3-c)*COMP_WIDTH-1 -: COMP_WIDTH] = {sign_r[c], mag_s};
      res_ovf_s[2-c] = sat_s;
    end
  end

  // Control FSM, divider datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      cnt_r           <= {CNT_W{1'b0}};
      dmag_r          <= {MAG_W{1'b0}};
      sign_r          <= 3'b000;
      dz_r            <= 1'b0;
      in_ready        <= 1'b1;
      out_valid       <= 1'b0;
      out_vector      <= {(3*COMP_WIDTH){1'b0}};
      out_overflow    <= 3'b000;
      out_div_by_zero <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        dvd_r[c]  <= {ITER{1'b0}};
        rem_r[c]  <= {MAG_W{1'b0}};
        quot_r[c] <= {ITER{1'b0}};
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            for (int c = 0; c < 3; c++) begin
              // Dividend is the component magnitude scaled up by FRAC_BITS so
              // the quotient keeps the same fixed-point format.
              dvd_r[c]  <= {in_vector[(3-c)*COMP_WIDTH-2 -: MAG_W], {FRAC_BITS{1'b0}}};
              rem_r[c]  <= {MAG_W{1'b0}};
              quot_r[c] <= {ITER{1'b0}};
              sign_r[c] <= in_vector[(3-c)*COMP_WIDTH-1] ^ in_scalar[COMP_WIDTH-1];
            end
            dmag_r   <= in_scalar[MAG_W-1:0];
            // A set sign bit with zero magnitude (-0) is still a zero divisor.
            dz_r     <= (in_scalar[MAG_W-1:0] == {MAG_W{1'b0}});
            cnt_r    <= {CNT_W{1'b0}};
            in_ready <= 1'b0;
            state_r  <= ST_DIV;
          end else begin
            in_ready <= 1'b1;
            state_r  <= ST_IDLE;
          end
        end
        ST_DIV: begin
          for (int c = 0; c < 3; c++) begin
            dvd_r[c]  <= {dvd_r[c][ITER-2:0], 1'b0};
            rem_r[c]  <= rem_nx_s[c];
            quot_r[c] <= quot_nx_s[c];
          end
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_ITER) begin
            out_vector      <= res_vec_s;
            out_overflow    <= res_ovf_s;
            out_div_by_zero <= dz_r;
            out_valid       <= 1'b1;
            state_r         <= ST_DONE;
          end else begin
            state_r <= ST_DIV;
          end
        end
        ST_DONE: begin
          // Result is held stable until the consumer takes it; a new operand
          // is only accepted from the following cycle onward.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
            state_r   <= ST_DONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_vector_scalar_division.sv
// Self-checking bench for signed_vector_scalar_division: directed and random
// operations through a scoreboard queue, backpressure and mid-divide reset.
module tb_signed_vector_scalar_division;

  localparam int CW   = 19;
  localparam int ITER = 28;

  typedef struct {
    logic [3*CW-1:0] vec;
    logic [2:0]      ovf;
    logic            dz;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3*CW-1:0] in_vector;
  logic [CW-1:0]   in_scalar;
  logic            out_valid;
  logic            out_ready;
  logic [3*CW-1:0] out_vector;
  logic [2:0]      out_overflow;
  logic            out_div_by_zero;

  int   checks_total;
  int   checks_passed;
  exp_t sb[$];

  signed_vector_scalar_division #(.COMP_WIDTH(CW), .FRAC_BITS(10)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_vector       (in_vector),
    .in_scalar       (in_scalar),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_vector      (out_vector),
    .out_overflow    (out_overflow),
    .out_div_by_zero (out_div_by_zero)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference quotient of one component by plain integer division.
  function automatic logic [CW-1:0] ref_comp(input logic [CW-1:0] a, input logic [CW-1:0] s,
                                             output logic ovf);
    logic [63:0] ma;
    logic [63:0] ms;
    logic [63:0] q;
    logic        sg;
    ma = 64'(a[CW-2:0]);
    ms = 64'(s[CW-2:0]);
    sg = a[CW-1] ^ s[CW-1];
    if (ms == 64'd0) begin
      ovf = 1'b1;
      q   = 64'h3FFFF;
    end else begin
      q = (ma << 10) / ms;
      if (q > 64'h3FFFF) begin
        ovf = 1'b1;
        q   = 64'h3FFFF;
      end else begin
        ovf = 1'b0;
      end
    end
    return {sg, q[CW-2:0]};
  endfunction

  function automatic exp_t ref_op(input logic [3*CW-1:0] v, input logic [CW-1:0] s);
    exp_t e;
    logic o;
    logic [CW-1:0] comp;
    for (int c = 0; c < 3; c++) begin
      comp = v[(3-c)*CW-1 -: CW];
      e.vec[(3-c)*CW-1 -: CW] = ref_comp(comp, s, o);
      e.ovf[2-c] = o;
    end
    e.dz = (s[CW-2:0] == 18'd0);
    return e;
  endfunction

  // One full transaction: accept, latency, result check, optional backpressure, handshake.
  task automatic do_op(input logic [3*CW-1:0] vec, input logic [CW-1:0] scal, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_vector = vec;
    in_scalar = scal;
    in_valid  = 1'b1;
    sb.push_back(ref_op(vec, scal));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_vector = {$urandom, $urandom};
    in_scalar = 19'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("latency", 64'(n), 64'(ITER));
    e = sb.pop_front();
    check_val("out_vector", 64'(out_vector), 64'(e.vec));
    check_val("out_overflow", 64'(out_overflow), 64'(e.ovf));
    check_val("out_div_by_zero", 64'(out_div_by_zero), 64'(e.dz));
    for (int k = 0; k < hold; k++) begin
      in_valid = k[0];
      check_val("hold_in_ready", 64'(in_ready), 64'd0);
      check_val("hold_out_valid", 64'(out_valid), 64'd1);
      check_val("hold_vector", 64'(out_vector), 64'(e.vec));
      check_val("hold_overflow", 64'(out_overflow), 64'(e.ovf));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("post_hs_out_valid", 64'(out_valid), 64'd0);
    check_val("post_hs_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [3*CW-1:0] v;
    logic [CW-1:0]   s;
    checks_total  = 0;
    checks_passed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_vector = '0;
    in_scalar = '0;
    #12;
    check_val("reset_out_valid", 64'(out_valid), 64'd0);
    check_val("reset_out_vector", 64'(out_vector), 64'd0);
    check_val("reset_out_overflow", 64'(out_overflow), 64'd0);
    check_val("reset_div_by_zero", 64'(out_div_by_zero), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("reset_in_ready", 64'(in_ready), 64'd1);

    // +2.0 / +0.5, -3.0 / +1.5 style cases and 1.0/3.0 truncation.
    do_op({19'h00800, 19'h00400, 19'h40C00}, 19'h00200, 0);
    do_op({19'h40C00, 19'h00400, 19'h00000}, 19'h00600, 0);
    do_op({19'h00400, 19'h40400, 19'h40000}, 19'h00C00, 0);
    // Saturation on x only.
    do_op({19'h32000, 19'h00400, 19'h40100}, 19'h00100, 0);
    // Negative zero divisor with mixed-sign vector, with backpressure.
    do_op({19'h00800, 19'h40C00, 19'h00001}, 19'h40000, 5);
    // Positive zero divisor and largest magnitudes.
    do_op({19'h3FFFF, 19'h7FFFF, 19'h00000}, 19'h00000, 0);
    do_op({19'h3FFFF, 19'h7FFFF, 19'h00001}, 19'h7FFFF, 2);

    // Abort mid-divide; pending result must not appear.
    in_vector = {19'h00800, 19'h00800, 19'h00800};
    in_scalar = 19'h00400;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("abort_out_valid", 64'(out_valid), 64'd0);
    check_val("abort_out_vector", 64'(out_vector), 64'd0);
    check_val("abort_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op({19'h40C00, 19'h00800, 19'h00200}, 19'h40600, 0);

    // Random operations, some with small divisors to hit saturation.
    for (int i = 0; i < 16; i++) begin
      v = {$urandom, $urandom};
      s = 19'($urandom);
      if (i % 4 == 1) begin
        s = {s[CW-1], 8'd0, s[9:0]};
      end else begin
        s = s;
      end
      do_op(v, s, i % 3);
    end

    check_val("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
